// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pulls fixed-length bursts out of a FIFO and
// presents them on a valid/ready stream through a 2-entry output buffer.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_threshold,
  input  logic                  fifo_overflow,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  flush,
  output logic                  rd,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  burst_done,
  output logic [15:0]           burst_cnt,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [3:0] BURST_BEATS = 4'(BURST_LEN);

  state_t                state_reg, state_next;
  logic [3:0]            beats_left_reg, beats_left_next;
  logic [1:0]            occ_reg, occ_next;
  logic                  inflight_reg, inflight_last_reg;
  logic                  head_reg, tail_reg;
  logic [DATA_WIDTH-1:0] buf_data_reg [2];
  logic                  buf_last_reg [2];
  logic [15:0]           burst_cnt_reg;
  logic                  burst_done_reg;
  logic                  err_overflow_reg, err_underflow_reg;

  logic                  pop, push, rd_last, done_set, room;
  logic [2:0]            pending;

  assign m_valid = (occ_reg != 2'd0);
  assign m_data  = m_valid ? buf_data_reg[head_reg] : '0;
  assign m_last  = m_valid & buf_last_reg[head_reg];
  assign pop     = m_valid & m_ready;
  assign push    = inflight_reg;
  assign rd_last = (beats_left_reg == 4'd1);

  // Buffered plus in-flight beats must stay within the 2 buffer slots.
  assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign room    = (pending < (3'd2 + {2'b00, pop}));

  assign busy          = (state_reg != IDLE);
  assign burst_done    = burst_done_reg;
  assign burst_cnt     = burst_cnt_reg;
  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;

  always_comb begin
    state_next      = state_reg;
    beats_left_next = beats_left_reg;
    rd              = 1'b0;
    done_set        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_threshold) begin
          state_next      = READ;
          beats_left_next = BURST_BEATS;
        end else if (flush && !fifo_empty) begin
          state_next      = READ;
          beats_left_next = 4'd1;
        end
      end
      READ: begin
        if (rst_n && (beats_left_reg != 4'd0) && !fifo_empty && room) begin
          rd              = 1'b1;
          beats_left_next = beats_left_reg - 4'd1;
          if (rd_last) state_next = WAIT;
        end
      end
      WAIT: begin
        if (pop && m_last) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      beats_left_reg    <= 4'd0;
      occ_reg           <= 2'd0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      head_reg          <= 1'b0;
      tail_reg          <= 1'b0;
      burst_cnt_reg     <= 16'd0;
      burst_done_reg    <= 1'b0;
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      beats_left_reg    <= beats_left_next;
      occ_reg           <= occ_next;
      inflight_reg      <= rd;
      inflight_last_reg <= rd & rd_last;
      if (push) tail_reg <= ~tail_reg;
      if (pop)  head_reg <= ~head_reg;
      burst_done_reg <= done_set;
      if (done_set) burst_cnt_reg <= burst_cnt_reg + 16'd1;
      if (fifo_overflow)  err_overflow_reg  <= 1'b1;
      if (fifo_underflow) err_underflow_reg <= 1'b1;
    end
  end

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          buf_data_reg[gi] <= '0;
          buf_last_reg[gi] <= 1'b0;
        end else if (push && (tail_reg == 1'(gi))) begin
          buf_data_reg[gi] <= data_out;
          buf_last_reg[gi] <= inflight_last_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a FIFO model feeds the DUT, and a burst-plan
// reference predicts every stream beat, its last tag and the burst count.
module tb_fifo_drain_ctrl;
  localparam int DW = 8;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty, fifo_threshold;
  logic          fifo_overflow = 1'b0, fifo_underflow = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          flush = 1'b0;
  logic          rd, m_valid, m_last, busy, burst_done;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
  logic [15:0]   burst_cnt;
  logic          err_overflow, err_underflow;

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow), .data_out(data_out),
    .flush(flush), .rd(rd), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .burst_done(burst_done), .burst_cnt(burst_cnt),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // FIFO model: writes come from tasks, reads from the DUT's rd.
  logic [DW-1:0] mem [4096];
  int  wr_total = 0;
  int  rd_total = 0;
  logic fifo_clr = 1'b0;
  assign fifo_empty     = (wr_total == rd_total);
  assign fifo_threshold = ((wr_total - rd_total) >= 8);

  always @(posedge clk) begin
    if (fifo_clr) rd_total <= wr_total;
    else if (rd && (rd_total != wr_total)) begin
      data_out <= mem[rd_total % 4096];
      rd_total <= rd_total + 1;
    end
  end

  // Reference: expected beats {last,data} in stream order, and burst count.
  logic [DW:0] exp_q[$];
  int exp_bursts = 0;

  // m_ready driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  int ready_mode = 0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_ready = (ph % 3 == 0);
        2:       m_ready = ($urandom % 4) != 0;
        default: m_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Stream monitor: order, last tags, empty guard, outstanding limit, pulse width.
  bit mon_en = 1'b1;
  int beats_seen = 0;
  int done_seen = 0;
  int outstanding = 0;
  bit prev_done = 1'b0;
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (rd) begin
          n_cmp++;
          if (fifo_empty) begin
            n_fail++;
            $display("FAIL rd_when_empty: rd=%0b fifo_empty=%0b, required rd=0", rd, fifo_empty);
          end
        end
        outstanding = outstanding + (rd ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        if (rd) begin
          n_cmp++;
          if (outstanding > 2) begin
            n_fail++;
            $display("FAIL outstanding: %0d beats outstanding, required <= 2", outstanding);
          end
        end
        if (m_valid && m_ready) begin
          n_cmp++;
          beats_seen++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra: got data=%02h last=%0b, required no beat", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            $display("beat %0d data=%02h last=%0b", beats_seen, m_data, m_last);
            if ({m_last, m_data} !== e) begin
              n_fail++;
              $display("FAIL beat: got data=%02h last=%0b, required data=%02h last=%0b",
                       m_data, m_last, e[DW-1:0], e[DW]);
            end
          end
        end
        if (burst_done) begin
          n_cmp++;
          done_seen++;
          if (prev_done) begin
            n_fail++;
            $display("FAIL burst_done_width: high 2 cycles, required 1-cycle pulse");
          end
        end
        prev_done = burst_done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Push n entries into the FIFO and record the beats the drain rules predict:
  // full 8-beat bursts while >=8 remain, then single-beat flush bursts.
  task automatic fill(input int n, input int base, input bit rnd);
    logic [DW-1:0] d;
    int full;
    bit last;
    full = (n / BL) * BL;
    for (int i = 0; i < n; i++) begin
      d = rnd ? DW'($urandom) : DW'(base + i);
      mem[wr_total % 4096] = d;
      wr_total++;
      last = (i < full) ? ((i % BL) == BL - 1) : 1'b1;
      exp_q.push_back({last, d});
    end
    exp_bursts += n / BL + n % BL;
    $display("fill n=%0d", n);
  endtask

  task automatic drain_wait(input int left_beats, input int bursts);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == left_beats && done_seen >= bursts && !busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    n_cmp++;
    if (!ok || busy) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats pending, %0d bursts seen; required %0d pending, %0d bursts",
               exp_q.size(), done_seen, left_beats, bursts);
    end
  endtask

  task automatic check_cnt(input string tag);
    n_cmp++;
    if (burst_cnt !== 16'(exp_bursts)) begin
      n_fail++;
      $display("FAIL %s burst_cnt: got %0d, required %0d", tag, burst_cnt, exp_bursts);
    end
  endtask

  task automatic test_reset();
    step();
    fill(8, 8'h01, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if ({rd, m_valid, m_data, m_last, busy, burst_done, burst_cnt, err_overflow, err_underflow} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: rd=%0b v=%0b d=%02h l=%0b busy=%0b done=%0b cnt=%0d eo=%0b eu=%0b, required all 0",
                 rd, m_valid, m_data, m_last, busy, burst_done, burst_cnt, err_overflow, err_underflow);
      end
    end
    rst_n = 1'b1;
    drain_wait(0, exp_bursts);
    check_cnt("reset_release");
  endtask

  task automatic test_burst();
    bit e_rd, e_v, e_l, e_done, e_busy;
    logic [DW-1:0] e_d;
    ready_mode = 0;
    step();
    fill(8, 8'h10, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      e_rd   = (k >= 1 && k <= 8);
      e_v    = (k >= 3 && k <= 10);
      e_d    = e_v ? DW'(8'h10 + k - 3) : '0;
      e_l    = (k == 10);
      e_done = (k == 11);
      e_busy = (k >= 1 && k <= 10);
      n_cmp++;
      if ({rd, m_valid, m_data, m_last, burst_done, busy} !== {e_rd, e_v, e_d, e_l, e_done, e_busy}) begin
        n_fail++;
        $display("FAIL burst_timing k=%0d: rd=%0b v=%0b d=%02h l=%0b done=%0b busy=%0b, required rd=%0b v=%0b d=%02h l=%0b done=%0b busy=%0b",
                 k, rd, m_valid, m_data, m_last, burst_done, busy, e_rd, e_v, e_d, e_l, e_done, e_busy);
      end
    end
    check_cnt("burst");
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    step();
    fill(8, 8'h20, 1'b0);
    drain_wait(0, exp_bursts);
    check_cnt("backpressure");
    ready_mode = 0;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    fill(3, 8'h30, 1'b0);
    drain_wait(0, exp_bursts);
    check_cnt("flush");
    n_cmp++;
    if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%0b fifo_empty=%0b, required busy=0 fifo_empty=1", busy, fifo_empty);
    end
    flush = 1'b0;
  endtask

  task automatic test_priority();
    flush = 1'b1;
    step();
    fill(9, 8'h40, 1'b0);
    drain_wait(0, exp_bursts);
    check_cnt("priority");
    flush = 1'b0;
  endtask

  task automatic test_errors();
    ready_mode = 2;
    step();
    fill(8, 8'h50, 1'b0);
    for (int k = 0; k < 4; k++) step();
    n_cmp++;
    if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pre: eo=%0b eu=%0b, required 0 0", err_overflow, err_underflow);
    end
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    n_cmp++;
    if (err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL err_overflow_set: eo=%0b eu=%0b, required 1 0", err_overflow, err_underflow);
    end
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    drain_wait(0, exp_bursts);
    n_cmp++;
    if (err_overflow !== 1'b1 || err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: eo=%0b eu=%0b, required 1 1", err_overflow, err_underflow);
    end
    check_cnt("errors");
    ready_mode = 0;
  endtask

  task automatic test_reset_mid_burst();
    int base;
    bit ok;
    base = beats_seen;
    ok = 1'b0;
    step();
    fill(8, 0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      if (beats_seen >= base + 4) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midreset_wait: %0d beats, required 4", beats_seen - base);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({rd, m_valid, m_data, m_last, busy, burst_done, burst_cnt, err_overflow, err_underflow} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rd=%0b v=%0b d=%02h l=%0b busy=%0b done=%0b cnt=%0d eo=%0b eu=%0b, required all 0",
               rd, m_valid, m_data, m_last, busy, burst_done, burst_cnt, err_overflow, err_underflow);
    end
    rst_n = 1'b1;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    exp_q.delete();
    exp_bursts = 0;
    done_seen = 0;
    outstanding = 0;
    prev_done = 1'b0;
    mon_en = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || burst_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy=%0b cnt=%0d, required 0 0", busy, burst_cnt);
    end
    fill(8, 8'h60, 1'b0);
    drain_wait(0, exp_bursts);
    check_cnt("midreset_restart");
  endtask

  task automatic test_random();
    int n;
    bit f;
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 16);
      f = 1'($urandom % 2);
      flush = f;
      step();
      fill(n, 0, 1'b1);
      if (!f) begin
        drain_wait(n % BL, exp_bursts - n % BL);
        flush = 1'b1;
      end
      drain_wait(0, exp_bursts);
      flush = 1'b0;
      check_cnt("random");
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_flush();
    test_priority();
    test_errors();
    test_reset_mid_burst();
    test_random();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
